// File: rtl/coke_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coke_pkg : shared state encoding, coin values and helpers for coke_ctl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package coke_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    COIN_ACK   = 4'd1,
    COIN_REL   = 4'd2,
    BILL_MOVE  = 4'd3,
    BILL_REL   = 4'd4,
    DISP_REQ   = 4'd5,
    DISP_REL   = 4'd6,
    COMMIT     = 4'd7,
    COMMIT_REL = 4'd8,
    CHG_REQ    = 4'd9,
    CHG_REL    = 4'd10,
    RET_REQ    = 4'd11,
    RET_REL    = 4'd12
  } state_t;

  localparam logic [7:0] C_VAL_Q = 8'd5;
  localparam logic [7:0] C_VAL_D = 8'd2;
  localparam logic [7:0] C_VAL_N = 8'd1;

  localparam int C_BILL_VAL_DFLT = 20;

  // one-hot change choice, ordered {Q, D, N}
  localparam logic [2:0] C_SEL_NONE = 3'b000;
  localparam logic [2:0] C_SEL_Q    = 3'b100;
  localparam logic [2:0] C_SEL_D    = 3'b010;
  localparam logic [2:0] C_SEL_N    = 3'b001;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/coke_chgsel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coke_chgsel : greedy change-coin picker (combinational)              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module coke_chgsel
  import coke_pkg::*;
(
  input  logic [7:0] i_credit,
  input  logic [2:0] i_numq,
  input  logic [2:0] i_numd,
  input  logic [2:0] i_numn,
  output logic [2:0] o_sel,
  output logic       o_none
);

  always_comb begin
    o_sel = C_SEL_NONE;
    if (i_credit != 8'd0) begin
      if (i_credit >= C_VAL_Q && i_numq != 3'd0)
        o_sel = C_SEL_Q;
      else if (i_credit >= C_VAL_D && i_numd != 3'd0)
        o_sel = C_SEL_D;
      else if (i_numn != 3'd0)
        o_sel = C_SEL_N;
    end
  end

  assign o_none = (i_credit != 8'd0) && (o_sel == C_SEL_NONE);

endmodule
`default_nettype wire

// File: rtl/coke_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coke_ctl : vending controller - coins, bills, vend, change, return   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module coke_ctl
  import coke_pkg::*;
#(
  parameter int BILL_VAL = C_BILL_VAL_DFLT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] COST,
  input  logic [5:0] EMPTY,
  input  logic [5:0] PRESS,
  input  logic       INSQ,
  input  logic       INSD,
  input  logic       INSN,
  input  logic [2:0] NUMQ,
  input  logic [2:0] NUMD,
  input  logic [2:0] NUMN,
  input  logic       BILLSNS,
  input  logic       BILLOK,
  input  logic       BILLNG,
  input  logic       CNRET,
  input  logic       BILLACK,
  input  logic       DISPACK,
  input  logic       CHGACK,
  output logic [5:0] DISP,
  output logic [5:0] ELIGHT,
  output logic       CHGQ,
  output logic       CHGD,
  output logic       CHGN,
  output logic       CHGCOM,
  output logic       RETINS,
  output logic       INSACK,
  output logic       BILLIN,
  output logic       BILLOUT,
  output logic       BILLLT,
  output logic       NOCHG
);

  localparam logic [7:0] C_BILL8 = 8'(BILL_VAL);

  state_t     r_state;
  logic [7:0] r_credit, r_bill_cr, r_cost;
  logic       r_ret_pend;
  logic [2:0] r_chg_sel;
  logic [5:0] r_disp, r_elight;
  logic       r_chgq, r_chgd, r_chgn, r_chgcom, r_retins, r_insack;
  logic       r_billin, r_billout, r_billlt, r_nochg;

  logic [2:0] w_chg_sel;
  logic       w_chg_none, w_nochg, w_coin_in, w_bill_room, w_vend_ok;
  logic [5:0] w_press_oh;
  logic [7:0] w_coin_val, w_chg_val;

  coke_chgsel u_chgsel (
    .i_credit (r_credit),
    .i_numq   (NUMQ),
    .i_numd   (NUMD),
    .i_numn   (NUMN),
    .o_sel    (w_chg_sel),
    .o_none   (w_chg_none)
  );

  assign w_nochg     = (NUMN == 3'd0) || (NUMD == 3'd0 && NUMN < 3'd2);
  assign w_coin_in   = INSQ | INSD | INSN;
  assign w_bill_room = ({1'b0, r_credit} + {1'b0, C_BILL8}) <= 9'd255;
  // only the lowest pressed button is considered; a refused press is dropped
  assign w_vend_ok   = ((w_press_oh & ~EMPTY) != 6'd0) && (r_credit >= COST);

  always_comb begin
    w_press_oh = 6'd0;
    for (int i = 5; i >= 0; i--) begin
      if (PRESS[i]) begin
        w_press_oh    = 6'd0;
        w_press_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_coin_val = C_VAL_N;
    if (INSQ)      w_coin_val = C_VAL_Q;
    else if (INSD) w_coin_val = C_VAL_D;
  end

  always_comb begin
    case (r_chg_sel)
      C_SEL_Q: w_chg_val = C_VAL_Q;
      C_SEL_D: w_chg_val = C_VAL_D;
      C_SEL_N: w_chg_val = C_VAL_N;
      default: w_chg_val = 8'd0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_credit   <= 8'd0;
      r_bill_cr  <= 8'd0;
      r_cost     <= 8'd0;
      r_ret_pend <= 1'b0;
      r_chg_sel  <= C_SEL_NONE;
      r_disp     <= 6'd0;
      r_elight   <= 6'd0;
      r_chgq     <= 1'b0;
      r_chgd     <= 1'b0;
      r_chgn     <= 1'b0;
      r_chgcom   <= 1'b0;
      r_retins   <= 1'b0;
      r_insack   <= 1'b0;
      r_billin   <= 1'b0;
      r_billout  <= 1'b0;
      r_billlt   <= 1'b0;
      r_nochg    <= 1'b0;
    end else begin
      r_elight <= EMPTY;
      r_nochg  <= w_nochg;
      r_billlt <= (r_state == IDLE) && !w_nochg;
      case (r_state)
        IDLE: begin
          if (CNRET) begin
            // bill money cannot go back through RETINS, so pay it out as change first
            if (r_bill_cr != 8'd0) begin
              r_credit   <= r_bill_cr;
              r_ret_pend <= 1'b1;
              r_state    <= CHG_REQ;
            end else begin
              r_retins <= 1'b1;
              r_state  <= RET_REQ;
            end
          end else if (w_coin_in) begin
            r_credit <= sat_add(r_credit, w_coin_val);
            r_state  <= COIN_ACK;
          end else if (BILLSNS && (BILLNG || (BILLOK && !w_bill_room))) begin
            r_billout <= 1'b1;
            r_state   <= BILL_MOVE;
          end else if (BILLSNS && BILLOK) begin
            r_billin <= 1'b1;
            r_state  <= BILL_MOVE;
          end else if (w_vend_ok) begin
            r_disp  <= w_press_oh;
            r_cost  <= COST;
            r_state <= DISP_REQ;
          end
        end
        COIN_ACK: begin
          r_insack <= 1'b1;
          r_state  <= COIN_REL;
        end
        COIN_REL: begin
          if (!w_coin_in) begin
            r_insack <= 1'b0;
            r_state  <= IDLE;
          end
        end
        BILL_MOVE: begin
          if (BILLACK) begin
            if (r_billin) begin
              r_credit  <= sat_add(r_credit, C_BILL8);
              r_bill_cr <= sat_add(r_bill_cr, C_BILL8);
            end
            r_billin  <= 1'b0;
            r_billout <= 1'b0;
            r_state   <= BILL_REL;
          end
        end
        BILL_REL: if (!BILLACK) r_state <= IDLE;
        DISP_REQ: begin
          if (DISPACK) begin
            r_disp  <= 6'd0;
            r_state <= DISP_REL;
          end
        end
        DISP_REL: begin
          if (!DISPACK) begin
            r_credit <= r_credit - r_cost;
            r_chgcom <= 1'b1;
            r_state  <= COMMIT;
          end
        end
        COMMIT: begin
          if (CHGACK) begin
            r_chgcom <= 1'b0;
            r_state  <= COMMIT_REL;
          end
        end
        COMMIT_REL: begin
          if (!CHGACK) begin
            r_bill_cr <= 8'd0;
            r_state   <= CHG_REQ;
          end
        end
        CHG_REQ: begin
          // first cycle picks a coin; the remaining cycles wait for its ack
          if (r_chg_sel == C_SEL_NONE) begin
            if (r_credit == 8'd0 || w_chg_none) begin
              r_credit <= 8'd0;
              if (r_ret_pend) begin
                r_retins <= 1'b1;
                r_state  <= RET_REQ;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_chg_sel                <= w_chg_sel;
              {r_chgq, r_chgd, r_chgn} <= w_chg_sel;
            end
          end else if (CHGACK) begin
            {r_chgq, r_chgd, r_chgn} <= 3'b000;
            r_state                  <= CHG_REL;
          end
        end
        CHG_REL: begin
          if (!CHGACK) begin
            r_credit  <= r_credit - w_chg_val;
            r_chg_sel <= C_SEL_NONE;
            r_state   <= CHG_REQ;
          end
        end
        RET_REQ: begin
          if (CHGACK) begin
            r_retins <= 1'b0;
            r_state  <= RET_REL;
          end
        end
        RET_REL: begin
          if (!CHGACK) begin
            r_credit   <= 8'd0;
            r_bill_cr  <= 8'd0;
            r_ret_pend <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DISP    = r_disp;
  assign ELIGHT  = r_elight;
  assign CHGQ    = r_chgq;
  assign CHGD    = r_chgd;
  assign CHGN    = r_chgn;
  assign CHGCOM  = r_chgcom;
  assign RETINS  = r_retins;
  assign INSACK  = r_insack;
  assign BILLIN  = r_billin;
  assign BILLOUT = r_billout;
  assign BILLLT  = r_billlt;
  assign NOCHG   = r_nochg;

endmodule
`default_nettype wire

// File: doc/coke_ctl.md
COKE_CTL -- requirements
Module: coke_ctl

Interface
REQ-001 SHALL have ports: CLK in 1 (sole clock, rising edge); RESET in 1 (asynchronous, active-high).
REQ-002 SHALL have inputs: COST 8 (price in nickels); EMPTY 6 (slot empty); PRESS 6 (selection buttons); INSQ/INSD/INSN 1 each (coin sensed); NUMQ/NUMD/NUMN 3 each (changer coin counts); BILLSNS, BILLOK, BILLNG 1 each (bill sensor, bill good, bill bad); CNRET 1 (coin-return button).
REQ-003 SHALL have handshake inputs: BILLACK, DISPACK, CHGACK 1 each.
REQ-004 SHALL have outputs: DISP 6 (dispense, one-hot); ELIGHT 6 (empty lights); CHGQ/CHGD/CHGN 1 each (eject one coin); CHGCOM 1 (commit inserted coins); RETINS 1 (return inserted coins); INSACK 1 (coin acknowledge); BILLIN/BILLOUT 1 each (bill motor); BILLLT 1 (insert-bill light); NOCHG 1 (exact-change light).
REQ-005 SHALL have parameter BILL_VAL, default 20, meaning bill value in nickels.

Function
REQ-006 SHALL register all outputs; each request output SHALL be one-hot across DISP/CHG*/CHGCOM/RETINS/BILLIN/BILLOUT.
REQ-007 SHALL hold an 8-bit credit register in nickels; additions SHALL saturate at 255.
REQ-008 SHALL use FSM states IDLE, COIN_ACK, COIN_REL, BILL_MOVE, BILL_REL, DISP_REQ, DISP_REL, COMMIT, COMMIT_REL, CHG_REQ, CHG_REL, RET_REQ, RET_REL.
REQ-009 In IDLE, events SHALL be serviced one per cycle with priority CNRET > coin > bill > PRESS; among coins Q > D > N; among PRESS, lowest index.
REQ-010 Coin: IDLE→COIN_ACK adds 5/2/1 to credit and drives INSACK=1 the next cycle; COIN_REL holds INSACK until all INS* are 0, then INSACK=0 and IDLE.
REQ-011 Bill: on BILLSNS with BILLOK, drive BILLIN=1; with BILLNG, or when credit+BILL_VAL>255, drive BILLOUT=1; hold until BILLACK=1, then drop and wait for BILLACK=0; BILLIN completion adds BILL_VAL.
REQ-012 Vend: PRESS[i] with EMPTY[i]=0 and credit>=COST drives DISP[i]=1 until DISPACK=1, then DISP=0, waits DISPACK=0, credit-=COST, then COMMIT; otherwise the press SHALL be ignored.
REQ-013 COMMIT drives CHGCOM=1 until CHGACK=1, then CHGCOM=0 and waits CHGACK=0.
REQ-014 Change: while credit>0, select greedily Q if credit>=5 and NUMQ>0, else D if credit>=2 and NUMD>0, else N if NUMN>0; assert that CHG* until CHGACK=1, drop, wait CHGACK=0, subtract 5/2/1.
REQ-015 If credit>0 and no coin is selectable, the remaining credit SHALL be forfeited (cleared) and the FSM SHALL return to IDLE.
REQ-016 CNRET SHALL drive RETINS=1 until CHGACK=1, then drop, wait CHGACK=0, clear credit; bill credit SHALL be refunded via REQ-014 before RETINS.
REQ-017 ELIGHT SHALL equal EMPTY registered one cycle; NOCHG SHALL be 1 when NUMN==0 or (NUMD==0 and NUMN<2); BILLLT SHALL be 1 in IDLE when NOCHG==0.
REQ-018 A change of COST SHALL take effect only at the next IDLE comparison.

Reset
REQ-019 RESET=1 SHALL asynchronously force IDLE, credit=0, and all outputs 0; an in-flight handshake SHALL be abandoned with no further request after release.

Structure
REQ-020 State encoding, coin values (5/2/1) and BILL_VAL default SHALL live in shared package coke_pkg.
REQ-021 Greedy coin selection SHALL be sub-module coke_chgsel (combinational: credit, NUMQ/D/N → one-hot choice plus none flag).

Verification
REQ-022 COST=3, insert Q then PRESS[2] with DISPACK after 3 cycles → DISP=6'b000100, CHGCOM, then CHGD once, credit 0.
REQ-023 COST=5, NUMQ=0, NUMD=0, NUMN=1, insert Q+Q (10) and vend → one CHGN, then the remaining 4 nickels are forfeited and the FSM returns to IDLE.
REQ-024 Simultaneous INSQ and CNRET with credit 4 → RETINS first, credit 0; then quarter acked, credit 5.
REQ-025 Credit 250, BILLSNS+BILLOK → BILLOUT=1, credit unchanged.
REQ-026 RESET asserted mid-DISP_REQ → DISP=0 same cycle, IDLE, credit 0.
REQ-027 PRESS[4] with EMPTY[4]=1 and credit 255 → no DISP, ELIGHT[4]=1.
